// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB command arbiter.
package apb_arb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StSettle,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: the first eligible index above rr_ptr_i, wrapping to 0.
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [IdxW-1:0] rr_ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  // Two passes: indices above the pointer first, then the wrap-around from 0 up to the pointer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!any_o && (i > int'(rr_ptr_i)) && eligible_i[i]) begin
        any_o      = 1'b1;
        idx_o      = IdxW'(i);
        grant_o[i] = 1'b1;
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!any_o && (i <= int'(rr_ptr_i)) && eligible_i[i]) begin
        any_o      = 1'b1;
        idx_o      = IdxW'(i);
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Round-robin sharing of the APB_TOP command port between NREQ requesters.
// Each command uses a fixed window: HOLD_CYCLES of transfer, then SETTLE_CYCLES before sampling.
// Optional: define APB_ARB_RETRY_EN to re-issue an errored command once before reporting.
module apb_cmd_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 5
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*APB_AW-1:0] req_addr,
  input  logic [NREQ*APB_DW-1:0] req_wdata,
  output logic [NREQ-1:0]        done,
  output logic [APB_DW-1:0]      rsp_rdata,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   transfer,
  output logic                   read,
  output logic                   write,
  output logic [APB_AW-1:0]      apb_waddr,
  output logic [APB_AW-1:0]      apb_raddr,
  output logic [APB_DW-1:0]      apb_wdata,
  input  logic [APB_DW-1:0]      apb_rdata,
  input  logic                   error
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                wr_q, wr_d;
  logic [APB_AW-1:0]   addr_q, addr_d;
  logic [APB_DW-1:0]   wdata_q, wdata_d;
  logic [APB_DW-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mask_vld_q, mask_vld_d;
  logic                retrying;

  logic [NREQ-1:0]     mask, eligible, pick_grant;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;

  // The last winner is masked for the single IDLE cycle after its DONE.
  assign mask     = mask_vld_q ? (NREQ'(1) << idx_q) : '0;
  assign eligible = req & ~mask;

  rr_picker #(
    .N    (NREQ),
    .IdxW (IdxW)
  ) u_picker (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

`ifdef APB_ARB_RETRY_EN
  logic retry_q, retry_d;
  assign retrying = (state_q == StDone) && err_q && !retry_q;
`else
  assign retrying = 1'b0;
`endif

  // Next-state: grant/latch in IDLE, shared down-counter paces ISSUE and SETTLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rr_ptr_d   = rr_ptr_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mask_vld_d = 1'b0;
`ifdef APB_ARB_RETRY_EN
    retry_d    = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StIssue;
          cnt_d   = HoldLoad;
          idx_d   = pick_idx;
          wr_d    = req_write[pick_idx];
          addr_d  = req_addr[APB_AW*pick_idx +: APB_AW];
          wdata_d = req_wdata[APB_DW*pick_idx +: APB_DW];
          rdata_d = '0;
          err_d   = 1'b0;
`ifdef APB_ARB_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      StIssue: begin
        err_d = err_q | error;
        if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = SettleLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        err_d = err_q | error;
        if (cnt_q == '0) begin
          state_d = StDone;
          rdata_d = wr_q ? '0 : apb_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (retrying) begin
          state_d = StIssue;
          cnt_d   = HoldLoad;
          err_d   = 1'b0;
`ifdef APB_ARB_RETRY_EN
          retry_d = 1'b1;
`endif
        end else begin
          state_d    = StIdle;
          rr_ptr_d   = idx_q;
          mask_vld_d = 1'b1;
`ifdef APB_ARB_RETRY_EN
          retry_d    = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them asynchronously.
  always_comb begin
    done      = '0;
    rsp_rdata = '0;
    rsp_error = 1'b0;
    transfer  = (state_q == StIssue);
    write     = (state_q == StIssue) && wr_q;
    read      = (state_q == StIssue) && !wr_q;
    apb_waddr = '0;
    apb_raddr = '0;
    apb_wdata = '0;
    busy      = (state_q != StIdle);
    if ((state_q == StIssue) || (state_q == StSettle)) begin
      if (wr_q) begin
        apb_waddr = addr_q;
        apb_wdata = wdata_q;
      end else begin
        apb_raddr = addr_q;
      end
    end
    if ((state_q == StDone) && !retrying) begin
      done[idx_q] = 1'b1;
      rsp_rdata   = rdata_q;
      rsp_error   = err_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      rr_ptr_q   <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mask_vld_q <= 1'b0;
`ifdef APB_ARB_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mask_vld_q <= mask_vld_d;
`ifdef APB_ARB_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule
